// File: rtl/riscv_if_pkg.sv
// ---------------------------------------------------------------------------
// riscv_if_pkg
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t : fetch FSM encoding (IDLE, REQ, WAIT)
//   INSTR_BYTES   : size of one instruction word in bytes (PC increment)
//   NOP_INSTR     : canonical RISC-V NOP (addi x0,x0,0)
// ---------------------------------------------------------------------------
package riscv_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_perf_counter.sv
// ---------------------------------------------------------------------------
// if_perf_counter
// 32-bit event counter that sticks at all-ones instead of wrapping.
// Ports:
//   CLK   in   clock, rising edge
//   RST   in   asynchronous active-high reset (count returns to 0)
//   inc   in   count one event this cycle
//   count out  registered event count
// ---------------------------------------------------------------------------
module if_perf_counter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_r;

    // Saturating increment: once all-ones is reached further events are dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_r <= 32'd0;
        end else if (inc && (count_r != 32'hFFFF_FFFF)) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: owns the PC, reads instruction memory as an
// Avalon-MM pipelined read master (one outstanding read), buffers one word
// and presents it to the IF/ID register.
//
// Parameters:
//   ADDR_W    PC / address width
//   RESET_PC  address of the first fetch after reset
// Ports:
//   CLK, RST           clock / asynchronous active-high reset
//   stall_i            hazard unit asks IF/ID to hold
//   redirect_i         one-cycle taken branch/jump pulse from EX
//   redirect_pc        redirect target (low two bits ignored)
//   avm_*              Avalon-MM read master to instruction memory
//   instr, PC, Add1    buffered word, its address, address+4
//   ifid_enable        IF/ID load strobe
//   ifid_clr           IF/ID flush strobe
//   stall_cnt,kill_cnt performance counters (only with IF_FETCH_PERF_CNT_EN)
//
// Optional build macro: IF_FETCH_PERF_CNT_EN adds the stall/kill counters.
// ---------------------------------------------------------------------------
module if_fetch_unit
    import riscv_if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] Add1,
`ifdef IF_FETCH_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       kill_cnt,
`endif
    output logic              ifid_enable,
    output logic              ifid_clr
);

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

    fetch_state_t      state_r;
    fetch_state_t      state_nxt_s;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] fetch_pc_nxt_s;
    logic [ADDR_W-1:0] pc_plus4_s;
    logic [ADDR_W-1:0] redir_tgt_s;
    logic              valid_r;
    logic              valid_nxt_s;
    logic              kill_r;
    logic              kill_nxt_s;
    logic              avm_read_r;
    logic [ADDR_W-1:0] avm_address_r;
    logic [31:0]       instr_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] add1_r;
    logic              ifid_enable_s;
    logic              rsp_s;
    logic              capture_s;
    logic              issue_s;

    assign redir_tgt_s   = redirect_pc & ALIGN_MASK;
    assign pc_plus4_s    = fetch_pc_r + PC_STEP;   // wraps modulo 2^ADDR_W
    assign ifid_enable_s = valid_r & ~stall_i & ~redirect_i;
    // Responses are only meaningful while waiting; stale ones in IDLE/REQ are dropped.
    assign rsp_s         = (state_r == WAIT) & avm_readdatavalid;
    // A redirect arriving with the response also invalidates that response.
    assign capture_s     = rsp_s & ~kill_r & ~redirect_i;
    assign issue_s       = (state_r == IDLE) & (state_nxt_s == REQ);

    // Next FSM state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!valid_r || ifid_enable_s) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (!avm_waitrequest) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (avm_readdatavalid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next fetch PC, buffer-valid and kill flag.
    always_comb begin
        fetch_pc_nxt_s = fetch_pc_r;
        valid_nxt_s    = valid_r;
        kill_nxt_s     = kill_r;

        if (redirect_i) begin
            fetch_pc_nxt_s = redir_tgt_s;
        end else if (capture_s) begin
            fetch_pc_nxt_s = pc_plus4_s;
        end else begin
            fetch_pc_nxt_s = fetch_pc_r;
        end

        if (redirect_i) begin
            valid_nxt_s = 1'b0;
        end else if (capture_s) begin
            valid_nxt_s = 1'b1;
        end else if (ifid_enable_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end

        // Any response in WAIT consumes the kill; a redirect while a read is
        // outstanding (and its data not arriving now) marks it for discard.
        if (rsp_s) begin
            kill_nxt_s = 1'b0;
        end else if (redirect_i && (state_r != IDLE)) begin
            kill_nxt_s = 1'b1;
        end else begin
            kill_nxt_s = kill_r;
        end
    end

    // FSM, PC and buffer-control state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            valid_r    <= 1'b0;
            kill_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            valid_r    <= valid_nxt_s;
            kill_r     <= kill_nxt_s;
        end
    end

    // Avalon request registers: address latched when the request is issued
    // (using the post-redirect PC) and held until the slave accepts it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            avm_read_r    <= 1'b0;
            avm_address_r <= RESET_PC;
        end else if (issue_s) begin
            avm_read_r    <= 1'b1;
            avm_address_r <= fetch_pc_nxt_s;
        end else if ((state_r == REQ) && !avm_waitrequest) begin
            avm_read_r    <= 1'b0;
            avm_address_r <= avm_address_r;
        end else begin
            avm_read_r    <= avm_read_r;
            avm_address_r <= avm_address_r;
        end
    end

    // Output buffer toward IF/ID.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr_r <= 32'd0;
            pc_r    <= {ADDR_W{1'b0}};
            add1_r  <= {ADDR_W{1'b0}};
        end else if (capture_s) begin
            instr_r <= avm_readdata;
            pc_r    <= fetch_pc_r;
            add1_r  <= pc_plus4_s;
        end else begin
            instr_r <= instr_r;
            pc_r    <= pc_r;
            add1_r  <= add1_r;
        end
    end

    assign avm_read    = avm_read_r;
    assign avm_address = avm_address_r;
    assign instr       = instr_r;
    assign PC          = pc_r;
    assign Add1        = add1_r;
    assign ifid_enable = ifid_enable_s;
    assign ifid_clr    = redirect_i;

`ifdef IF_FETCH_PERF_CNT_EN
    logic stall_evt_s;
    logic kill_evt_s;

    assign stall_evt_s = valid_r & stall_i;
    assign kill_evt_s  = rsp_s & (kill_r | redirect_i);

    if_perf_counter u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_evt_s),
        .count (stall_cnt)
    );

    if_perf_counter u_kill_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (kill_evt_s),
        .count (kill_cnt)
    );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit. Main instance uses RESET_PC=0; a second
// instance uses RESET_PC=32'hFFFF_FFFC for the PC+4 wrap case. Memory word at
// address a is a ^ 32'h1234_0013.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;
    import riscv_if_pkg::*;

    logic        CLK;
    logic        RST;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [31:0] instr;
    logic [31:0] PC;
    logic [31:0] Add1;
    logic        ifid_enable;
    logic        ifid_clr;

    logic        w_rst;
    logic        w_zero;
    logic [31:0] w_zero32;
    logic [31:0] w_address;
    logic        w_read;
    logic [31:0] w_rdata;
    logic        w_rdv;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_add1;
    logic        w_en;
    logic        w_clr;

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] kill_cnt;
    logic [31:0] w_stall_cnt;
    logic [31:0] w_kill_cnt;
`endif

    int          n_checks;
    int          n_fail;
    int          lat;
    int          pend;
    logic [31:0] pend_addr;

    if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc(redirect_pc), .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .instr(instr), .PC(PC), .Add1(Add1),
`ifdef IF_FETCH_PERF_CNT_EN
        .stall_cnt(stall_cnt), .kill_cnt(kill_cnt),
`endif
        .ifid_enable(ifid_enable), .ifid_clr(ifid_clr)
    );

    if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .CLK(CLK), .RST(w_rst), .stall_i(w_zero), .redirect_i(w_zero),
        .redirect_pc(w_zero32), .avm_address(w_address), .avm_read(w_read),
        .avm_waitrequest(w_zero), .avm_readdata(w_rdata),
        .avm_readdatavalid(w_rdv), .instr(w_instr), .PC(w_pc), .Add1(w_add1),
`ifdef IF_FETCH_PERF_CNT_EN
        .stall_cnt(w_stall_cnt), .kill_cnt(w_kill_cnt),
`endif
        .ifid_enable(w_en), .ifid_clr(w_clr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_0013;
    endfunction

    // One clock: starts and ends at a falling edge; plays the memory slaves.
    task automatic step();
        logic        acc;
        logic        accw;
        logic [31:0] a;
        logic [31:0] aw;
        acc  = avm_read && !avm_waitrequest;
        a    = avm_address;
        accw = w_read;
        aw   = w_address;
        @(posedge CLK);
        #1;
        avm_readdatavalid = 1'b0;
        avm_readdata      = NOP_INSTR;
        if (acc) begin
            pend_addr = a;
            pend      = lat;
        end
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = mem_word(pend_addr);
            end
        end
        w_rdv   = accw;
        w_rdata = accw ? mem_word(aw) : NOP_INSTR;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL rst_read got %0h want 0", avm_read); end
        n_checks++; if (avm_address !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %0h want 0", avm_address); end
        n_checks++; if ({instr, PC, Add1} !== 96'h0) begin n_fail++; $display("FAIL rst_buf got %0h/%0h/%0h want 0/0/0", instr, PC, Add1); end
        n_checks++; if ({ifid_enable, ifid_clr} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got %b want 00", {ifid_enable, ifid_clr}); end
        n_checks++; if (w_address !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_wrap_addr got %0h want fffffffc", w_address); end
`ifdef IF_FETCH_PERF_CNT_EN
        n_checks++; if ({stall_cnt, kill_cnt} !== 64'h0) begin n_fail++; $display("FAIL rst_cnt got %0h/%0h want 0/0", stall_cnt, kill_cnt); end
`endif
    endtask

    task automatic test_fetch();
        RST = 1'b0;
        step();  // IDLE -> REQ 0
        n_checks++; if ({avm_read, avm_address} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL fetch_req0 got %b/%0h want 1/0", avm_read, avm_address); end
        step();  // accepted -> WAIT
        n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL fetch_wait0_read got %b want 0", avm_read); end
        step();  // capture word 0
        n_checks++; if ({instr, PC, Add1} !== {32'h1234_0013, 32'h0, 32'h4}) begin n_fail++; $display("FAIL fetch_cap0 got %0h/%0h/%0h want 12340013/0/4", instr, PC, Add1); end
        n_checks++; if (ifid_enable !== 1'b1) begin n_fail++; $display("FAIL fetch_en0 got %b want 1", ifid_enable); end
        step();  // consumed -> REQ 4
        n_checks++; if ({avm_read, avm_address, ifid_enable} !== {1'b1, 32'h4, 1'b0}) begin n_fail++; $display("FAIL fetch_req4 got %b/%0h/%b want 1/4/0", avm_read, avm_address, ifid_enable); end
        step();
        step();  // capture word 4
        n_checks++; if ({instr, PC, Add1} !== {32'h1234_0017, 32'h4, 32'h8}) begin n_fail++; $display("FAIL fetch_cap4 got %0h/%0h/%0h want 12340017/4/8", instr, PC, Add1); end
        n_checks++; if (ifid_enable !== 1'b1) begin n_fail++; $display("FAIL fetch_en4 got %b want 1", ifid_enable); end
        step();  // REQ 8
        n_checks++; if ({avm_read, avm_address} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL fetch_req8 got %b/%0h want 1/8", avm_read, avm_address); end
    endtask

    task automatic test_waitrequest();
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if ({avm_read, avm_address} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL wreq_hold%0d got %b/%0h want 1/8", i, avm_read, avm_address); end
        end
        avm_waitrequest = 1'b0;
        step();
        step();
        n_checks++; if ({instr, PC, Add1} !== {32'h1234_001B, 32'h8, 32'hC}) begin n_fail++; $display("FAIL wreq_cap got %0h/%0h/%0h want 1234001b/8/c", instr, PC, Add1); end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        #1;
        n_checks++; if (ifid_enable !== 1'b0) begin n_fail++; $display("FAIL stall_en0 got %b want 0", ifid_enable); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if ({ifid_enable, avm_read, PC, instr} !== {1'b0, 1'b0, 32'h8, 32'h1234_001B}) begin n_fail++; $display("FAIL stall_hold%0d got en=%b rd=%b pc=%0h instr=%0h want 0/0/8/1234001b", i, ifid_enable, avm_read, PC, instr); end
        end
        stall_i = 1'b0;
        #1;
        n_checks++; if (ifid_enable !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b want 1", ifid_enable); end
        step();  // REQ 0xC: exactly one capture happened during the wait-state test
        n_checks++; if ({avm_read, avm_address} !== {1'b1, 32'hC}) begin n_fail++; $display("FAIL stall_next_req got %b/%0h want 1/c", avm_read, avm_address); end
    endtask

    task automatic test_redirect();
        step();
        step();  // capture 0xC
        step();  // REQ 0x10
        n_checks++; if (avm_address !== 32'h10) begin n_fail++; $display("FAIL redir_req10 got %0h want 10", avm_address); end
        lat = 2;
        step();  // WAIT for 0x10, response one cycle later
        redirect_i  = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        n_checks++; if ({ifid_clr, ifid_enable} !== 2'b10) begin n_fail++; $display("FAIL redir_clr got %b want 10", {ifid_clr, ifid_enable}); end
        step();
        redirect_i = 1'b0;
        #1;
        n_checks++; if (ifid_clr !== 1'b0) begin n_fail++; $display("FAIL redir_clr_once got %b want 0", ifid_clr); end
        step();  // 0x10 response arrives and must be discarded
        n_checks++; if ({PC, ifid_enable} !== {32'hC, 1'b0}) begin n_fail++; $display("FAIL redir_discard got pc=%0h en=%b want c/0", PC, ifid_enable); end
        lat = 1;
        step();  // REQ at redirect target
        n_checks++; if ({avm_read, avm_address} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL redir_req100 got %b/%0h want 1/100", avm_read, avm_address); end
        step();
        step();
        n_checks++; if ({instr, PC, Add1} !== {32'h1234_0113, 32'h100, 32'h104}) begin n_fail++; $display("FAIL redir_cap got %0h/%0h/%0h want 12340113/100/104", instr, PC, Add1); end
    endtask

    task automatic test_reset_in_flight();
        lat = 3;
        step();  // REQ 0x104
        step();  // accepted, response is late
        RST = 1'b1;
        #1;
        n_checks++; if ({avm_read, avm_address, instr, PC, Add1, ifid_enable} !== {1'b0, 32'h0, 96'h0, 1'b0}) begin n_fail++; $display("FAIL rstw_outputs got rd=%b a=%0h i=%0h pc=%0h a1=%0h en=%b want all 0", avm_read, avm_address, instr, PC, Add1, ifid_enable); end
`ifdef IF_FETCH_PERF_CNT_EN
        n_checks++; if ({stall_cnt, kill_cnt} !== 64'h0) begin n_fail++; $display("FAIL rstw_cnt got %0h/%0h want 0/0", stall_cnt, kill_cnt); end
`endif
        step();
        RST = 1'b0;
        step();  // IDLE -> REQ at RESET_PC; stale response now on the bus
        n_checks++; if ({avm_read, avm_address} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL rstw_restart got %b/%0h want 1/0", avm_read, avm_address); end
        lat = 1;
        step();  // stale response seen in REQ, must be ignored
        n_checks++; if ({instr, PC} !== 64'h0) begin n_fail++; $display("FAIL rstw_stale got %0h/%0h want 0/0", instr, PC); end
        step();
        n_checks++; if ({instr, PC, Add1} !== {32'h1234_0013, 32'h0, 32'h4}) begin n_fail++; $display("FAIL rstw_cap got %0h/%0h/%0h want 12340013/0/4", instr, PC, Add1); end
    endtask

    task automatic test_wrap();
        w_rst = 1'b0;
        step();
        n_checks++; if ({w_read, w_address} !== {1'b1, 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL wrap_req got %b/%0h want 1/fffffffc", w_read, w_address); end
        step();
        step();
        n_checks++; if ({w_instr, w_pc, w_add1} !== {32'hEDCB_FFEF, 32'hFFFF_FFFC, 32'h0}) begin n_fail++; $display("FAIL wrap_cap got %0h/%0h/%0h want edcbffef/fffffffc/0", w_instr, w_pc, w_add1); end
        step();
        n_checks++; if ({w_read, w_address} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL wrap_next got %b/%0h want 1/0", w_read, w_address); end
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        lat               = 1;
        pend              = 0;
        pend_addr         = 32'h0;
        RST               = 1'b1;
        w_rst             = 1'b1;
        w_zero            = 1'b0;
        w_zero32          = 32'h0;
        stall_i           = 1'b0;
        redirect_i        = 1'b0;
        redirect_pc       = 32'h0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = NOP_INSTR;
        avm_readdatavalid = 1'b0;
        w_rdata           = NOP_INSTR;
        w_rdv             = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        test_reset();
        test_fetch();
        test_waitrequest();
        test_stall();
        test_redirect();
        test_reset_in_flight();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
